// File: rtl/cpu_isa_pkg.sv
// Purpose: opcode constants, fetch-state and length-class types shared by the front end and tools.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: OP_* opcode bytes of the supported x86 subset, fetch_state_e for the
// fetch/decode sequencer, len_class_e for the opcode length lookup, and a helper
// that turns a length class into a total instruction byte count.
package cpu_isa_pkg;

    // Supported opcodes
    localparam logic [7:0] OP_PUSH_EBP = 8'h55;
    localparam logic [7:0] OP_MOV      = 8'h89;
    localparam logic [7:0] OP_MOV_IMM  = 8'hb8;
    localparam logic [7:0] OP_POP_EBP  = 8'h5d;
    localparam logic [7:0] OP_RET      = 8'hc3;
    localparam logic [7:0] OP_CALL     = 8'he8;

    // Immediate operands are always 32-bit little-endian
    localparam int IMM_BYTES = 4;

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_MODRM,
        FETCH_IMM,
        ISSUE,
        HALT
    } fetch_state_e;

    typedef enum logic [1:0] {
        LEN_1,
        LEN_MODRM,
        LEN_IMM32,
        LEN_ILLEGAL
    } len_class_e;

    // Total instruction length in bytes for a class; 0 marks an illegal opcode.
    function automatic logic [2:0] len_class_bytes(input len_class_e cls);
        logic [2:0] n;
        n = 3'd0;
        case (cls)
            LEN_1:     n = 3'd1;
            LEN_MODRM: n = 3'd2;
            LEN_IMM32: n = 3'd5;
            default:   n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/op_length_decode.sv
// Purpose: maps an opcode byte to its instruction length class.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state and no handshake.
//
// Ports:
//   opcode    in  8  candidate opcode byte
//   len_class out    LEN_1 / LEN_MODRM / LEN_IMM32 / LEN_ILLEGAL
module op_length_decode
    import cpu_isa_pkg::*;
(
    input  logic [7:0] opcode,
    output len_class_e len_class
);

    always_comb begin
        len_class = LEN_ILLEGAL;
        case (opcode)
            OP_PUSH_EBP,
            OP_POP_EBP,
            OP_RET:      len_class = LEN_1;
            OP_MOV:      len_class = LEN_MODRM;
            OP_MOV_IMM,
            OP_CALL:     len_class = LEN_IMM32;
            default:     len_class = LEN_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Purpose: byte-serial instruction fetch and length decode feeding the ALU stage.
// Latency: one cycle per instruction byte with zero-wait memory, plus one issue cycle.
// Backpressure: holds the assembled instruction in ISSUE until instr_ready; no reads meanwhile.
//
// Ports:
//   clock, reset                   rising-edge clock, asynchronous active-high reset
//   mem_addr/mem_rd                byte read request (one outstanding, address stable until mem_valid)
//   mem_data/mem_valid             returned byte; mem_valid completes the read
//   ope/modrm/immidiate_data       assembled instruction fields, qualified by instr_valid
//   instr_valid/instr_ready        issue handshake toward the ALU
//   eip                            first byte of the next instruction to fetch
//   eip_load/eip_new               redirect (call/ret); aborts any partial instruction
//   illegal_op                     sticky; set on an unknown opcode, fetch then halts until reset
module instr_fetch_decode
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_EIP = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic [31:0]       ope,
    output logic [7:0]        modrm,
    output logic [31:0]       immidiate_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] eip,
    input  logic              eip_load,
    input  logic [ADDR_W-1:0] eip_new,
    output logic              illegal_op
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e      state;
    logic [ADDR_W-1:0] fptr;      // address of the next byte to read
    logic [1:0]        imm_cnt;   // immediate byte index, little-endian
    len_class_e        op_class;
    logic [ADDR_W-1:0] fptr_inc;
    logic              rd_done;

    // The opcode is classified straight off the memory bus so the next state
    // is known in the same cycle the opcode byte arrives.
    op_length_decode u_op_length_decode (
        .opcode    (mem_data),
        .len_class (op_class)
    );

    // Natural ADDR_W-bit wrap: FF + 1 -> 00.
    assign fptr_inc = fptr + ADDR_ONE;
    assign rd_done  = mem_rd && mem_valid;

    // mem_rd/mem_addr are registered and always set up for the state being
    // entered, so a zero-wait memory completes a read in every fetch cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= FETCH_OP;
            fptr           <= RESET_EIP;
            eip            <= RESET_EIP;
            mem_addr       <= RESET_EIP;
            mem_rd         <= 1'b0;
            ope            <= 32'h0;
            modrm          <= 8'h0;
            immidiate_data <= 32'h0;
            imm_cnt        <= 2'd0;
            instr_valid    <= 1'b0;
            illegal_op     <= 1'b0;
        end else if (eip_load && (state != HALT)) begin
            // Redirect beats everything else, including a same-cycle accept
            // or a returning byte; partial bytes are dropped.
            state          <= FETCH_OP;
            fptr           <= eip_new;
            eip            <= eip_new;
            mem_addr       <= eip_new;
            mem_rd         <= 1'b1;
            modrm          <= 8'h0;
            immidiate_data <= 32'h0;
            imm_cnt        <= 2'd0;
            instr_valid    <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (!mem_rd) begin
                        // Only reached right after reset: start the first read.
                        mem_rd   <= 1'b1;
                        mem_addr <= fptr;
                    end else if (mem_valid) begin
                        ope      <= {24'h0, mem_data};
                        fptr     <= fptr_inc;
                        mem_addr <= fptr_inc;
                        case (op_class)
                            LEN_1: begin
                                state       <= ISSUE;
                                mem_rd      <= 1'b0;
                                instr_valid <= 1'b1;
                            end
                            LEN_MODRM: begin
                                state <= FETCH_MODRM;
                            end
                            LEN_IMM32: begin
                                state   <= FETCH_IMM;
                                imm_cnt <= 2'd0;
                            end
                            default: begin
                                state      <= HALT;
                                mem_rd     <= 1'b0;
                                illegal_op <= 1'b1;
                            end
                        endcase
                    end
                end

                FETCH_MODRM: begin
                    if (rd_done) begin
                        modrm       <= mem_data;
                        fptr        <= fptr_inc;
                        mem_addr    <= fptr_inc;
                        mem_rd      <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                FETCH_IMM: begin
                    if (rd_done) begin
                        immidiate_data[8*imm_cnt +: 8] <= mem_data;
                        imm_cnt  <= imm_cnt + 2'd1;
                        fptr     <= fptr_inc;
                        mem_addr <= fptr_inc;
                        if (imm_cnt == 2'(IMM_BYTES - 1)) begin
                            mem_rd      <= 1'b0;
                            instr_valid <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (instr_ready) begin
                        // ope is left as-is; only the optional fields clear.
                        eip            <= fptr;
                        instr_valid    <= 1'b0;
                        modrm          <= 8'h0;
                        immidiate_data <= 32'h0;
                        mem_rd         <= 1'b1;
                        mem_addr       <= fptr;
                        state          <= FETCH_OP;
                    end
                end

                HALT: begin
                    mem_rd      <= 1'b0;
                    instr_valid <= 1'b0;
                end

                default: begin
                    state       <= HALT;
                    mem_rd      <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Purpose: self-checking bench for instr_fetch_decode against a byte-level memory model.
// Latency: n/a.
// Backpressure: drives instr_ready low/high and memory wait states.
module tb_instr_fetch_decode;

    logic        clock;
    logic        reset;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic [31:0] ope;
    logic [7:0]  modrm;
    logic [31:0] immidiate_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  eip;
    logic        eip_load;
    logic [7:0]  eip_new;
    logic        illegal_op;

    instr_fetch_decode #(.ADDR_W(8), .RESET_EIP(8'h00)) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .mem_valid      (mem_valid),
        .ope            (ope),
        .modrm          (modrm),
        .immidiate_data (immidiate_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .eip            (eip),
        .eip_load       (eip_load),
        .eip_new        (eip_new),
        .illegal_op     (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program memory: a read completes after wait_cfg stall cycles.
    logic [7:0] mem [0:255];
    int         wait_cfg;
    int         wcnt;
    logic [7:0] rd_log [$];

    assign mem_valid = mem_rd && (wcnt >= wait_cfg);
    assign mem_data  = mem[mem_addr];

    always @(posedge clock or posedge reset) begin
        if (reset)                     wcnt <= 0;
        else if (mem_rd && !mem_valid) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end

    always @(posedge clock) begin
        if (!reset && mem_rd && mem_valid) rd_log.push_back(mem_addr);
    end

    int total;
    int bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_issue(input string name, output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk({name, "_issue"}, {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic redirect(input logic [7:0] a);
        eip_load = 1'b1;
        eip_new  = a;
        @(negedge clock);
        eip_load = 1'b0;
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(negedge clock);
        instr_ready = 1'b0;
    endtask

    // Reference: instruction length straight from the opcode table.
    function automatic int len_of(input logic [7:0] op);
        case (op)
            8'h55, 8'h5d, 8'hc3: return 1;
            8'h89:               return 2;
            8'hb8, 8'he8:        return 5;
            default:             return 0;
        endcase
    endfunction

    typedef struct {
        logic [7:0]  addr;
        int          n;
        logic [39:0] b;      // byte i at b[8*i +: 8]
        int          wt;
        logic [31:0] ope;
        logic [7:0]  modrm;
        logic [31:0] imm;
        logic [7:0]  eip;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] addr, input int n, input logic [39:0] b,
                                input int wt, input logic [31:0] op, input logic [7:0] mr,
                                input logic [31:0] imm, input logic [7:0] ne);
        vec_t v;
        v.addr = addr; v.n = n; v.b = b; v.wt = wt;
        v.ope = op; v.modrm = mr; v.imm = imm; v.eip = ne;
        return v;
    endfunction

    typedef struct {
        logic [31:0] ope;
        logic [7:0]  modrm;
        logic [31:0] imm;
        logic [7:0]  eip;
    } exp_t;

    vec_t tbl [8];
    exp_t exp_q [$];

    initial begin
        int          cyc;
        int          base;
        int          rc;
        logic [7:0]  a;
        logic [7:0]  t;
        logic        saw_valid;
        exp_t        e;
        logic [7:0]  ops [6];
        logic [31:0] pl_ope [4];
        logic [7:0]  pl_mrm [4];
        logic [7:0]  pl_eip [4];
        int          pl_cyc [4];

        total = 0; bad = 0;
        reset = 1'b1; instr_ready = 1'b0; eip_load = 1'b0; eip_new = 8'h00; wait_cfg = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h55;

        tbl[0] = mk(8'h10, 1, 40'h55,           0, 32'h55, 8'h00, 32'h0,        8'h11);
        tbl[1] = mk(8'h20, 2, 40'he589,         1, 32'h89, 8'he5, 32'h0,        8'h22);
        tbl[2] = mk(8'h30, 5, 40'h12345678b8,   2, 32'hb8, 8'h00, 32'h12345678, 8'h35);
        tbl[3] = mk(8'h48, 5, 40'h00000001e8,   0, 32'he8, 8'h00, 32'h00000001, 8'h4d);
        tbl[4] = mk(8'hfe, 5, 40'hddccbbaab8,   1, 32'hb8, 8'h00, 32'hddccbbaa, 8'h03);
        tbl[5] = mk(8'h80, 1, 40'hc3,           0, 32'hc3, 8'h00, 32'h0,        8'h81);
        tbl[6] = mk(8'h90, 1, 40'h5d,           3, 32'h5d, 8'h00, 32'h0,        8'h91);
        tbl[7] = mk(8'ha0, 2, 40'h0089,         0, 32'h89, 8'h00, 32'h0,        8'ha2);

        // Reset state
        @(negedge clock);
        chk("rst_eip", {24'h0, eip}, 32'h0);
        chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_ope", ope, 32'h0);
        chk("rst_modrm", {24'h0, modrm}, 32'h0);
        chk("rst_imm", immidiate_data, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_illegal", {31'h0, illegal_op}, 32'h0);

        // Straight-line program, zero wait, consumer always ready
        mem[0] = 8'h55; mem[1] = 8'h89; mem[2] = 8'he5; mem[3] = 8'h5d; mem[4] = 8'hc3;
        pl_ope = '{32'h55, 32'h89, 32'h5d, 32'hc3};
        pl_mrm = '{8'h00, 8'he5, 8'h00, 8'h00};
        pl_eip = '{8'h01, 8'h03, 8'h04, 8'h05};
        pl_cyc = '{2, 2, 1, 1};
        instr_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_issue("prog", cyc);
            chk("prog_cycles", cyc, pl_cyc[i]);
            chk("prog_ope", ope, pl_ope[i]);
            chk("prog_modrm", {24'h0, modrm}, {24'h0, pl_mrm[i]});
            chk("prog_imm", immidiate_data, 32'h0);
            @(negedge clock);
            chk("prog_eip", {24'h0, eip}, {24'h0, pl_eip[i]});
        end
        instr_ready = 1'b0;

        // Table: one instruction per entry, reached by redirect
        for (int k = 0; k < 8; k++) begin
            wait_issue("park", cyc);
            for (int i = 0; i < tbl[k].n; i++) begin
                t = tbl[k].addr + 8'(i);
                mem[t] = tbl[k].b[8*i +: 8];
            end
            wait_cfg = tbl[k].wt;
            redirect(tbl[k].addr);
            base = rd_log.size();
            wait_issue("tbl", cyc);
            chk("tbl_ope", ope, tbl[k].ope);
            chk("tbl_modrm", {24'h0, modrm}, {24'h0, tbl[k].modrm});
            chk("tbl_imm", immidiate_data, tbl[k].imm);
            chk("tbl_nreads", rd_log.size() - base, tbl[k].n);
            for (int i = 0; i < tbl[k].n && base + i < rd_log.size(); i++)
                chk("tbl_rd_addr", {24'h0, rd_log[base+i]}, {24'h0, tbl[k].addr + 8'(i)});
            accept();
            chk("tbl_eip", {24'h0, eip}, {24'h0, tbl[k].eip});
            chk("tbl_valid_drop", {31'h0, instr_valid}, 32'h0);
        end

        // Consumer stall: outputs stable, no reads while waiting
        wait_cfg = 0;
        wait_issue("park", cyc);
        mem[8'h50] = 8'he8; mem[8'h51] = 8'h01; mem[8'h52] = 8'h00;
        mem[8'h53] = 8'h00; mem[8'h54] = 8'h00;
        redirect(8'h50);
        wait_issue("stall", cyc);
        rc = rd_log.size();
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'h0, instr_valid}, 32'h1);
            chk("stall_fields", ope ^ immidiate_data, 32'he9);
            chk("stall_imm", immidiate_data, 32'h1);
            chk("stall_mem_rd", {31'h0, mem_rd}, 32'h0);
            @(negedge clock);
        end
        chk("stall_no_reads", rd_log.size(), rc);
        accept();
        chk("stall_eip", {24'h0, eip}, 32'h55);

        // Redirect in the middle of an immediate
        wait_issue("park", cyc);
        mem[8'h60] = 8'hb8; mem[8'h61] = 8'h11; mem[8'h62] = 8'h22;
        mem[8'h63] = 8'h33; mem[8'h64] = 8'h44; mem[8'h40] = 8'h5d;
        redirect(8'h60);
        base = rd_log.size();
        cyc = 0;
        while (rd_log.size() - base < 3 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        chk("abort_reads", rd_log.size() - base, 3);
        redirect(8'h40);
        chk("abort_addr", {24'h0, mem_addr}, 32'h40);
        chk("abort_rd", {31'h0, mem_rd}, 32'h1);
        chk("abort_eip", {24'h0, eip}, 32'h40);
        chk("abort_valid", {31'h0, instr_valid}, 32'h0);
        wait_issue("abort", cyc);
        chk("abort_ope", ope, 32'h5d);
        chk("abort_imm", immidiate_data, 32'h0);

        // Redirect and accept in the same cycle: redirect wins
        mem[8'h70] = 8'hc3;
        instr_ready = 1'b1;
        redirect(8'h70);
        instr_ready = 1'b0;
        chk("both_eip", {24'h0, eip}, 32'h70);
        chk("both_valid", {31'h0, instr_valid}, 32'h0);
        wait_issue("both", cyc);
        chk("both_ope", ope, 32'hc3);

        // Random instruction streams vs. reference decode
        ops = '{8'h55, 8'h5d, 8'hc3, 8'h89, 8'hb8, 8'he8};
        for (int r = 0; r < 3; r++) begin
            wait_issue("park", cyc);
            for (int i = 0; i < 256; i++) mem[i] = 8'h55;
            wait_cfg = r;
            a = 8'($urandom);
            exp_q.delete();
            redirect(a);
            for (int n = 0; n < 30; n++) begin
                e.ope = {24'h0, ops[$urandom_range(0, 5)]};
                e.modrm = 8'h00;
                e.imm = 32'h0;
                mem[a] = e.ope[7:0];
                for (int j = 1; j < len_of(e.ope[7:0]); j++) begin
                    t = a + 8'(j);
                    mem[t] = 8'($urandom);
                    if (len_of(e.ope[7:0]) == 2) e.modrm = mem[t];
                    else e.imm[8*(j-1) +: 8] = mem[t];
                end
                a = a + 8'(len_of(e.ope[7:0]));
                e.eip = a;
                exp_q.push_back(e);
            end
            // Memory was rewritten after the redirect: park on the old stream first.
            wait_issue("rpark", cyc);
            redirect(exp_q[0].eip - 8'(len_of(exp_q[0].ope[7:0])));
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 5000) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                if (instr_valid && instr_ready) begin
                    e = exp_q.pop_front();
                    chk("rand_ope", ope, e.ope);
                    chk("rand_modrm", {24'h0, modrm}, {24'h0, e.modrm});
                    chk("rand_imm", immidiate_data, e.imm);
                    @(negedge clock);
                    cyc++;
                    chk("rand_eip", {24'h0, eip}, {24'h0, e.eip});
                end else begin
                    @(negedge clock);
                    cyc++;
                end
            end
            instr_ready = 1'b0;
            chk("rand_left", exp_q.size(), 0);
        end

        // Illegal opcode halts; only reset recovers
        wait_cfg = 0;
        wait_issue("park", cyc);
        mem[8'h10] = 8'h0f;
        redirect(8'h10);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            saw_valid = saw_valid | instr_valid;
        end
        chk("ill_flag", {31'h0, illegal_op}, 32'h1);
        chk("ill_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("ill_no_valid", {31'h0, saw_valid}, 32'h0);
        redirect(8'h20);
        @(negedge clock);
        chk("ill_load_ignored", {31'h0, mem_rd}, 32'h0);
        chk("ill_eip", {24'h0, eip}, 32'h10);
        chk("ill_sticky", {31'h0, illegal_op}, 32'h1);

        #2 reset = 1'b1;
        #1;
        chk("arst_eip", {24'h0, eip}, 32'h0);
        chk("arst_mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("arst_ope", ope, 32'h0);
        chk("arst_illegal", {31'h0, illegal_op}, 32'h0);
        chk("arst_mem_rd", {31'h0, mem_rd}, 32'h0);
        mem[0] = 8'h5d;
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
        while (!mem_rd && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("restart_rd", {31'h0, mem_rd}, 32'h1);
        chk("restart_addr", {24'h0, mem_addr}, 32'h0);
        wait_issue("restart", cyc);
        chk("restart_ope", ope, 32'h5d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
